// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: configurable data width and stop-bit count, runtime parity,
// 3-sample majority vote and framing/parity/overrun/break error reporting.
module uart_rx_ext #(
    parameter int N           = 8,
    parameter int SAMPLE_RATE = 16,
    parameter int STOP_BITS   = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rx_en,
    input  logic         rx_in,
    input  logic [1:0]   parity_mode,
    input  logic         ready_clr,
    output logic         ready,
    output logic [N-1:0] rx_out,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun_err,
    output logic         break_det
);

    localparam int CW = $clog2(SAMPLE_RATE);
    localparam int IW = $clog2(N);
    localparam int H  = SAMPLE_RATE / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_RATE - 1);
    localparam logic [CW-1:0] CNT_V0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(H);
    localparam logic [CW-1:0] CNT_VOTE = CW'(H + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t        state, state_next;
    logic          sync1, rx_sync;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          stop_idx;
    logic [N-1:0]  shift;
    logic [1:0]    pmode;
    logic          perr, ferr, zero_run;
    logic          v0, v1;

    logic at_vote, end_bit, vote, par_en, last_stop, complete, ferr_now, brk_now;

    always_comb begin
        at_vote   = rx_en && (cnt == CNT_VOTE);
        end_bit   = rx_en && (cnt == CNT_LAST);
        vote      = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);
        par_en    = (pmode == 2'b01) || (pmode == 2'b10);
        last_stop = (STOP_BITS == 1) || stop_idx;
        complete  = (state == STOP) && at_vote && last_stop;
        ferr_now  = ferr | ~vote;
        // with two stop bits the break decision was already folded in on the first one
        brk_now   = stop_idx ? zero_run : (zero_run & ~vote);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_sync) state_next = START;
            START: begin
                if (at_vote && vote) state_next = IDLE;
                else if (end_bit)    state_next = DATA;
            end
            DATA:      if (end_bit && idx == IDX_LAST) state_next = par_en ? PARITY : STOP;
            PARITY:    if (end_bit) state_next = STOP;
            STOP:      if (complete) state_next = ferr_now ? WAIT_HIGH : IDLE;
            WAIT_HIGH: if (rx_sync) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b1;
            rx_sync  <= 1'b1;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            pmode    <= 2'b00;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            zero_run <= 1'b0;
            v0       <= 1'b1;
            v1       <= 1'b1;
        end else begin
            sync1   <= rx_in;
            rx_sync <= sync1;
            if (state == IDLE) begin
                cnt      <= '0;
                idx      <= '0;
                stop_idx <= 1'b0;
                if (!rx_sync) begin
                    pmode    <= parity_mode;
                    perr     <= 1'b0;
                    ferr     <= 1'b0;
                    zero_run <= 1'b1;
                end
            end else if (rx_en) begin
                // leaving for IDLE/WAIT_HIGH mid-bit must not leave a stale count behind
                cnt <= (cnt == CNT_LAST || state_next == IDLE || state_next == WAIT_HIGH)
                       ? '0 : cnt + 1'b1;
                if (cnt == CNT_V0) v0 <= rx_sync;
                if (cnt == CNT_V1) v1 <= rx_sync;
                case (state)
                    START: if (end_bit) idx <= '0;
                    DATA: begin
                        if (at_vote) begin
                            shift[idx] <= vote;
                            zero_run   <= zero_run & ~vote;
                        end
                        if (end_bit && idx != IDX_LAST) idx <= idx + 1'b1;
                    end
                    PARITY: begin
                        if (at_vote) begin
                            perr     <= vote != ((^shift) ^ pmode[1]);
                            zero_run <= zero_run & ~vote;
                        end
                    end
                    STOP: begin
                        if (at_vote) begin
                            ferr <= ferr_now;
                            if (!stop_idx) zero_run <= zero_run & ~vote;
                        end
                        if (end_bit) stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // completion takes priority over a simultaneous host acknowledge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready       <= 1'b0;
            rx_out      <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else if (complete) begin
            ready       <= 1'b1;
            rx_out      <= shift;
            frame_err   <= ferr_now;
            parity_err  <= perr;
            break_det   <= brk_now;
            overrun_err <= ready & ~ready_clr;
        end else if (ready_clr) begin
            ready       <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: one receiver with 1 stop bit and rx_en every clock,
// a second with 2 stop bits and rx_en one clock in four.
module tb_uart_rx_ext;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_en_a = 1'b1;
    logic       rx_en_b = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       ready_clr = 1'b0;

    logic       ready_a, ferr_a, perr_a, oerr_a, brk_a;
    logic [7:0] out_a;
    logic       ready_b, ferr_b, perr_b, oerr_b, brk_b;
    logic [7:0] out_b;

    int checks = 0;
    int errors = 0;
    int div = 0;

    always #5 clk = ~clk;

    uart_rx_ext #(.N(8), .SAMPLE_RATE(16), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .rx_en(rx_en_a), .rx_in(rx_a),
        .parity_mode(parity_mode), .ready_clr(ready_clr), .ready(ready_a),
        .rx_out(out_a), .frame_err(ferr_a), .parity_err(perr_a),
        .overrun_err(oerr_a), .break_det(brk_a)
    );

    uart_rx_ext #(.N(8), .SAMPLE_RATE(16), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .rx_en(rx_en_b), .rx_in(rx_b),
        .parity_mode(parity_mode), .ready_clr(ready_clr), .ready(ready_b),
        .rx_out(out_b), .frame_err(ferr_b), .parity_err(perr_b),
        .overrun_err(oerr_b), .break_det(brk_b)
    );

    // rx_en for the second receiver: one clock in four
    initial begin
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            rx_en_b = (div == 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drives bits[0] first; each bit lasts cpb clocks
    task automatic send(input bit which, input logic [15:0] bits, input int nbits, input int cpb);
        for (int i = 0; i < nbits; i++) begin
            if (which) rx_b = bits[i];
            else       rx_a = bits[i];
            tick(cpb);
        end
    endtask

    task automatic clear_ready;
        ready_clr = 1'b1;
        tick(1);
        ready_clr = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(3);
        checks++;
        if ({ready_a, ferr_a, perr_a, oerr_a, brk_a, out_a} !== 13'h0) begin
            errors++;
            $display("[TB] FAIL reset_a got %b expected 0", {ready_a, ferr_a, perr_a, oerr_a, brk_a, out_a});
        end
        checks++;
        if ({ready_b, ferr_b, perr_b, oerr_b, brk_b, out_b} !== 13'h0) begin
            errors++;
            $display("[TB] FAIL reset_b got %b expected 0", {ready_b, ferr_b, perr_b, oerr_b, brk_b, out_b});
        end
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_basic;
        send(1'b0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16);
        checks++;
        if (out_a !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data got %h expected a5", out_a); end
        checks++;
        if ({ready_a, ferr_a, perr_a, oerr_a, brk_a} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL basic_flags got %b expected 10000", {ready_a, ferr_a, perr_a, oerr_a, brk_a});
        end
        ready_clr = 1'b1;
        tick(1);
        ready_clr = 1'b0;
        checks++;
        if (ready_a !== 1'b0) begin errors++; $display("[TB] FAIL basic_clr got %b expected 0", ready_a); end
    endtask

    task automatic test_parity;
        parity_mode = 2'b01;
        send(1'b0, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 16);
        checks++;
        if (out_a !== 8'h3C) begin errors++; $display("[TB] FAIL even_data got %h expected 3c", out_a); end
        checks++;
        if ({ready_a, ferr_a, perr_a} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL even_perr got %b expected 101", {ready_a, ferr_a, perr_a});
        end
        clear_ready();
        parity_mode = 2'b10;
        send(1'b0, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 16);
        checks++;
        if ({ready_a, ferr_a, perr_a, out_a} !== {3'b100, 8'h3C}) begin
            errors++;
            $display("[TB] FAIL odd_ok got %b expected 10000111100", {ready_a, ferr_a, perr_a, out_a});
        end
        clear_ready();
        parity_mode = 2'b00;
    endtask

    task automatic test_glitch;
        rx_a = 1'b0;
        tick(4);
        rx_a = 1'b1;
        tick(40);
        checks++;
        if ({ready_a, ferr_a, perr_a, oerr_a, brk_a} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL glitch got %b expected 00000", {ready_a, ferr_a, perr_a, oerr_a, brk_a});
        end
    endtask

    task automatic test_overrun;
        send(1'b0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 16);
        checks++;
        if ({ready_a, oerr_a, out_a} !== {2'b10, 8'h55}) begin
            errors++;
            $display("[TB] FAIL first_55 got %b expected 1001010101", {ready_a, oerr_a, out_a});
        end
        send(1'b0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 16);
        checks++;
        if (out_a !== 8'h0F) begin errors++; $display("[TB] FAIL overrun_data got %h expected 0f", out_a); end
        checks++;
        if ({ready_a, oerr_a} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL overrun_flag got %b expected 11", {ready_a, oerr_a});
        end
        clear_ready();
        checks++;
        if (oerr_a !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clr got %b expected 0", oerr_a); end
        send(1'b0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 16);
        // completion lands in the cycle before edge 157 after the start bit is driven
        fork
            send(1'b0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 16);
            begin
                tick(156);
                ready_clr = 1'b1;
                tick(1);
                ready_clr = 1'b0;
            end
        join
        checks++;
        if ({ready_a, oerr_a, out_a} !== {2'b10, 8'h0F}) begin
            errors++;
            $display("[TB] FAIL clr_on_complete got %b expected 1000001111", {ready_a, oerr_a, out_a});
        end
        clear_ready();
    endtask

    task automatic test_break;
        rx_a = 1'b0;
        tick(200);
        checks++;
        if ({ready_a, ferr_a, brk_a, out_a} !== {3'b111, 8'h00}) begin
            errors++;
            $display("[TB] FAIL break got %b expected 11100000000", {ready_a, ferr_a, brk_a, out_a});
        end
        clear_ready();
        tick(280);
        checks++;
        if (ready_a !== 1'b0) begin errors++; $display("[TB] FAIL held_low_refire got %b expected 0", ready_a); end
        rx_a = 1'b1;
        tick(20);
        send(1'b0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, 16);
        checks++;
        if ({ready_a, ferr_a, perr_a, oerr_a, brk_a, out_a} !== {5'b10000, 8'h81}) begin
            errors++;
            $display("[TB] FAIL after_break got %b expected 1000010000001",
                     {ready_a, ferr_a, perr_a, oerr_a, brk_a, out_a});
        end
    endtask

    task automatic test_stop2;
        send(1'b1, {5'b0, 1'b0, 1'b1, 8'h96, 1'b0}, 11, 64);
        rx_b = 1'b1;
        checks++;
        if (out_b !== 8'h96) begin errors++; $display("[TB] FAIL stop2_data got %h expected 96", out_b); end
        checks++;
        if ({ready_b, ferr_b, perr_b, brk_b} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL stop2_ferr got %b expected 1100", {ready_b, ferr_b, perr_b, brk_b});
        end
        tick(20);
    endtask

    task automatic test_reset_mid;
        send(1'b0, 16'b1010, 4, 16);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ready_a, ferr_a, perr_a, oerr_a, brk_a, out_a} !== 13'h0) begin
            errors++;
            $display("[TB] FAIL midreset_a got %b expected 0", {ready_a, ferr_a, perr_a, oerr_a, brk_a, out_a});
        end
        checks++;
        if ({ready_b, ferr_b, perr_b, oerr_b, brk_b, out_b} !== 13'h0) begin
            errors++;
            $display("[TB] FAIL midreset_b got %b expected 0", {ready_b, ferr_b, perr_b, oerr_b, brk_b, out_b});
        end
        rx_a = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        send(1'b0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 16);
        checks++;
        if ({ready_a, ferr_a, perr_a, oerr_a, brk_a, out_a} !== {5'b10000, 8'hC3}) begin
            errors++;
            $display("[TB] FAIL c3_a got %b expected 1000011000011",
                     {ready_a, ferr_a, perr_a, oerr_a, brk_a, out_a});
        end
        send(1'b1, {5'b0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11, 64);
        checks++;
        if ({ready_b, ferr_b, perr_b, oerr_b, brk_b, out_b} !== {5'b10000, 8'hC3}) begin
            errors++;
            $display("[TB] FAIL c3_b got %b expected 1000011000011",
                     {ready_b, ferr_b, perr_b, oerr_b, brk_b, out_b});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_overrun();
        test_break();
        test_stop2();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised successor to the team's 8-bit oversampling UART receiver. It adds:
- configurable data width and stop-bit count,
- runtime-selectable parity,
- 3-sample majority voting,
- framing, parity, overrun and break error reporting.

It sits between the pad-side serial input and the host register interface. The shared baud generator drives its rx_en tick at SAMPLE_RATE x baud.

Parameters:
N, 8, data bits per frame, legal 5..9, LSB first
SAMPLE_RATE, 16, rx_en ticks per bit, even, legal 8..64
STOP_BITS, 1, stop bits checked per frame, legal 1 or 2

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
rx_en  input  1  oversample tick, one clk wide; all bit timing advances only on cycles with rx_en=1
rx_in  input  1  asynchronous serial line, idle high
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none; captured on IDLE->START
ready_clr  input  1  host acknowledge; clears ready and all error flags
ready  output  1  frame available in rx_out
rx_out  output  N  last received data word
frame_err  output  1  a stop bit sampled 0 in the last frame
parity_err  output  1  parity mismatch in the last frame
overrun_err  output  1  a frame completed while ready was still 1
break_det  output  1  line held low for the whole frame

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, counters=0.
  - Both synchroniser flops=1.
  - All outputs 0; rx_out=0.
- Synchroniser: rx_in passes through 2 flops to give rx_sync. All decisions use rx_sync.
- Sample counter: width $clog2(SAMPLE_RATE). It increments per rx_en and wraps to 0 at SAMPLE_RATE-1, which ends the bit. H=SAMPLE_RATE/2.
- Bit value: majority of rx_sync taken at counter values H-1, H and H+1. The value is decided on the H+1 tick.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - Counter and index held at 0.
  - rx_sync==0 -> START, capture parity_mode.
  - Entry does not require rx_en.
- START:
  - At the H+1 vote: 1 -> IDLE (false start, no flags); 0 -> continue.
  - At end of bit -> DATA, index=0.
- DATA:
  - Vote is written to shift[index].
  - At end of bit: index==N-1 -> PARITY if parity is enabled, else STOP. Otherwise index+1.
- PARITY:
  - Expected bit = XOR(data) for even, ~XOR(data) for odd.
  - A mismatch sets the internal perr.
  - At end of bit -> STOP.
- STOP:
  - Each stop bit is voted. Any 0 sets the internal ferr.
  - The frame completes at the H+1 vote of the last stop bit, without waiting for the end of the bit, so back-to-back frames resynchronise.
  - On completion: ferr=0 -> IDLE; ferr=1 -> WAIT_HIGH.
- WAIT_HIGH: stays until rx_sync==1, then -> IDLE. This prevents a false start from a held-low line.
- Completion, all updated on the same clk edge:
  - ready<=1 and rx_out<=shift; the word is delivered even on error.
  - frame_err<=ferr, parity_err<=perr.
  - break_det<=1 if all data bits, the parity bit (if enabled) and the first stop bit voted 0. break_det implies frame_err.
  - overrun_err<=1 if ready==1 and ready_clr==0 in that cycle. rx_out is overwritten.
- ready_clr:
  - Clears ready, frame_err, parity_err, overrun_err and break_det on the next edge.
  - If a completion occurs in the same cycle, the completion wins: flags take the new frame's values, ready=1, overrun_err=0.
- Error flags are sticky until ready_clr or the next completion. A later good frame clears frame_err, parity_err and break_det.
- rx_en=0: state, counter and index are frozen. The synchroniser and ready_clr still act.
- Latency:
  - ready rises one clk after the rx_en tick at count H+1 of the last stop bit.
  - This is (1+N+P+STOP_BITS-1)*SAMPLE_RATE+H+2 ticks after START entry, where P=1 if parity is enabled.
- reset_n asserted mid-frame: immediate return to the reset state. The partial frame is discarded with no flags.
- Unused index and counter width bits are never compared. Index width is $clog2(N).

Test Plan:
1. N=8, SAMPLE_RATE=16, parity none, send 0xA5 with rx_en every clk -> rx_out=0xA5, ready=1, all errors 0. ready_clr -> ready=0 next cycle.
2. Even parity, send 0x3C with parity bit 1 (wrong) -> rx_out=0x3C, ready=1, parity_err=1. Repeat with odd parity and bit 1 -> parity_err=0.
3. 4-clk glitch low on idle line (shorter than H-1 ticks) -> returns to IDLE, ready stays 0, no flags.
4. Send 0x55 then 0x0F with no ready_clr between -> rx_out=0x0F, overrun_err=1. Repeat with ready_clr pulsed on the completion cycle -> overrun_err=0.
5. Line held low for 3 frame times -> ready=1, rx_out=0x00, frame_err=1, break_det=1. No second frame until the line returns high, then 0x81 is received cleanly with all flags 0.
6. STOP_BITS=2, second stop bit low, rx_en one clk in 4 -> frame_err=1. Separately, reset_n pulsed low mid-DATA -> all outputs 0 and the next frame 0xC3 is received correctly.
